// File: rtl/rom_arbiter.sv
// Shares the single-port instruction ROM between the fetch and data ports.
// Per-cycle arbitration, window check and one-cycle-late response routing.
module rom_arbiter #(
  parameter logic [31:0] ROM_BASE        = 32'h0000_0000,
  parameter int unsigned ROM_WORDS       = 8192,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [31:0] rom_addr_o,
  output logic        rom_cs_o,
  input  logic [31:0] rom_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA
  } owner_e;

  localparam logic [32:0] WIN_BYTES  = 33'(ROM_WORDS) << 2;
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_DATA_STREAK);

  logic [3:0]  streak_q;
  owner_e      owner_q;
  logic        err_q;
  logic [31:0] addr_q;

  logic [31:0] i_off;
  logic [31:0] d_off;
  logic [31:0] sel_off;
  logic        i_in;
  logic        d_in;
  logic        sel_in;
  logic        win_i;
  logic        win_d;
  logic        any_gnt;

  // Offsets wrap modulo 2^32, so addresses below the base land far out.
  always_comb begin
    i_off   = instr_addr_i - ROM_BASE;
    d_off   = data_addr_i - ROM_BASE;
    i_in    = {1'b0, i_off} < WIN_BYTES;
    d_in    = {1'b0, d_off} < WIN_BYTES;
    win_d   = HRESETn && data_req_i &&
              (!instr_req_i || streak_q != STREAK_MAX);
    win_i   = HRESETn && instr_req_i && !win_d;
    any_gnt = win_i || win_d;
    sel_off = win_d ? d_off : i_off;
    sel_in  = win_d ? d_in : i_in;
  end

  assign instr_gnt_o = win_i;
  assign data_gnt_o  = win_d;
  assign rom_cs_o    = any_gnt && sel_in;
  assign rom_addr_o  = rom_cs_o ? {sel_off[31:2], 2'b00} : addr_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      streak_q <= 4'd0;
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      addr_q   <= 32'h0;
    end else begin
      if (rom_cs_o)
        addr_q <= {sel_off[31:2], 2'b00};
      // Data can only win against a waiting fetch below the limit.
      if (win_d && instr_req_i)
        streak_q <= streak_q + 4'd1;
      else
        streak_q <= 4'd0;
      unique case (1'b1)
        win_d:   owner_q <= OWN_DATA;
        win_i:   owner_q <= OWN_INSTR;
        default: owner_q <= OWN_NONE;
      endcase
      err_q <= any_gnt && !sel_in;
    end
  end

  always_comb begin
    instr_rvalid_o = owner_q == OWN_INSTR;
    data_rvalid_o  = owner_q == OWN_DATA;
    instr_err_o    = instr_rvalid_o && err_q;
    data_err_o     = data_rvalid_o && err_q;
    instr_rdata_o  = (instr_rvalid_o && !err_q) ? rom_rdata_i : 32'h0;
    data_rdata_o   = (data_rvalid_o && !err_q) ? rom_rdata_i : 32'h0;
  end

endmodule
